// File: rtl/display_scan_ctrl_pkg.sv
// display_scan_ctrl_pkg: scan FSM states, digit count, default refresh constants, anode one-hot helper
package display_scan_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BLANK = 2'd1, SHOW = 2'd2} scan_state_t;
  localparam int NUM_DIGITS = 4;
  localparam int DEF_REFRESH_DIV = 100000;
  localparam int DEF_BLANK_CYCLES = 1000;
  function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [1:0] s);
    return {{(NUM_DIGITS-1){1'b0}}, 1'b1} << s;
  endfunction
endpackage

// File: rtl/display_scan_ctrl_slot_timer.sv
// display_scan_ctrl_slot_timer: loadable down-counter (in: load, load_val; out: tc when count is zero)
module display_scan_ctrl_slot_timer
  import display_scan_ctrl_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? load_val : cnt - 1'b1;
  assign tc = cnt == '0;
endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit 7-seg scan FSM with blanking (in: en, digit_en, dp_in; out: sel, an, dp, slot_tick)
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int BLANK_CYCLES = DEF_BLANK_CYCLES,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NUM_DIGITS-1:0] digit_en,
  input  logic [NUM_DIGITS-1:0] dp_in,
  output logic [1:0]            sel,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp,
  output logic                  slot_tick
);
  localparam int W = $clog2(REFRESH_DIV);
  localparam logic [W-1:0] BLANK_LD = W'(BLANK_CYCLES - 1);
  localparam logic [W-1:0] SHOW_LD = W'(REFRESH_DIV - BLANK_CYCLES - 1);
  scan_state_t state, nxt_state;
  logic [1:0] nxt_sel;
  logic [W-1:0] load_val;
  logic tc, adv, load, on;
  always_comb begin
    adv = en && state == SHOW && tc;
    nxt_state = !en ? IDLE : state == BLANK ? (tc ? SHOW : BLANK) : (state == SHOW && !tc) ? SHOW : BLANK;
    nxt_sel = (!en || state == IDLE) ? 2'd0 : sel + {1'b0, adv};
    load = !en || state == IDLE || tc;
    load_val = !en ? '0 : state == BLANK ? SHOW_LD : BLANK_LD;
    on = nxt_state == SHOW;
  end
  display_scan_ctrl_slot_timer #(.W(W)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .load_val(load_val),
    .tc(tc)
  );
  // outputs are computed from the next state so they change on the same edge as state/sel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sel <= '0;
      an <= {NUM_DIGITS{ACTIVE_LOW}};
      dp <= ACTIVE_LOW;
      slot_tick <= 1'b0;
    end else begin
      state <= nxt_state;
      sel <= nxt_sel;
      slot_tick <= adv;
      an <= {NUM_DIGITS{ACTIVE_LOW}} ^ ((on && digit_en[nxt_sel]) ? digit_onehot(nxt_sel) : '0);
      dp <= ACTIVE_LOW ^ (on && dp_in[nxt_sel]);
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: randomized scan check against a time-since-enable model plus literal pins
module tb_display_scan_ctrl;
  localparam int RD = 8;
  localparam int BC = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [3:0] digit_en = 4'h0;
  logic [3:0] dp_in = 4'h0;
  logic [1:0] sel;
  logic [3:0] an;
  logic dp, slot_tick;
  int n_chk = 0;
  int n_fail = 0;
  display_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .digit_en(digit_en),
    .dp_in(dp_in),
    .sel(sel),
    .an(an),
    .dp(dp),
    .slot_tick(slot_tick)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask
  bit running = 1'b0;
  int k = 0;
  logic [1:0] e_sel;
  logic [3:0] e_an;
  logic e_dp, e_tick;
  always @(posedge clk) begin
    int slot, pos, s;
    bit show;
    if (!rst_n) running = 1'b0;
    else if (!en) running = 1'b0;
    else if (!running) begin
      running = 1'b1;
      k = 0;
    end else k++;
    if (!running) begin
      e_sel = 2'd0; e_an = 4'hF; e_dp = 1'b1; e_tick = 1'b0;
    end else begin
      slot = k / RD;
      pos = k % RD;
      s = slot % 4;
      show = pos >= BC;
      e_sel = 2'(s);
      e_an = (show && digit_en[s]) ? 4'hF ^ (4'b0001 << s) : 4'hF;
      e_dp = !(show && dp_in[s]);
      e_tick = pos == 0 && slot > 0;
    end
    #1;
    chk("model_sel", {2'b0, sel}, {2'b0, e_sel});
    chk("model_an", an, e_an);
    chk("model_dp", {3'b0, dp}, {3'b0, e_dp});
    chk("model_tick", {3'b0, slot_tick}, {3'b0, e_tick});
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (5) @(negedge clk);
    chk("rst_sel", {2'b0, sel}, 4'h0);
    chk("rst_an", an, 4'hF);
    chk("rst_dp", {3'b0, dp}, 4'h1);
    chk("rst_tick", {3'b0, slot_tick}, 4'h0);
    rst_n = 1'b1;
    @(negedge clk);
    digit_en = 4'hF; dp_in = 4'b0100; en = 1'b1;
    @(negedge clk);
    chk("k0_an", an, 4'hF);
    chk("k0_tick", {3'b0, slot_tick}, 4'h0);
    @(negedge clk);
    chk("k1_an", an, 4'hF);
    @(negedge clk);
    chk("k2_an", an, 4'hE);
    chk("k2_dp", {3'b0, dp}, 4'h1);
    repeat (6) @(negedge clk);
    chk("k8_sel", {2'b0, sel}, 4'h1);
    chk("k8_tick", {3'b0, slot_tick}, 4'h1);
    chk("k8_an", an, 4'hF);
    repeat (2) @(negedge clk);
    chk("k10_an", an, 4'hD);
    repeat (8) @(negedge clk);
    chk("k18_sel", {2'b0, sel}, 4'h2);
    chk("k18_an", an, 4'hB);
    chk("k18_dp", {3'b0, dp}, 4'h0);
    repeat (14) @(negedge clk);
    chk("k32_sel", {2'b0, sel}, 4'h0);
    chk("k32_tick", {3'b0, slot_tick}, 4'h1);
    repeat (20) @(negedge clk);
    chk("k52_an", an, 4'hB);
    en = 1'b0;
    @(negedge clk);
    chk("drop_an", an, 4'hF);
    chk("drop_sel", {2'b0, sel}, 4'h0);
    en = 1'b1;
    @(negedge clk);
    chk("re_k0_an", an, 4'hF);
    chk("re_k0_tick", {3'b0, slot_tick}, 4'h0);
    @(negedge clk);
    chk("re_k1_an", an, 4'hF);
    @(negedge clk);
    chk("re_k2_an", an, 4'hE);
    digit_en = 4'b1010;
    repeat (8) @(negedge clk);
    chk("de_k10_an", an, 4'hD);
    repeat (8) @(negedge clk);
    chk("de_k18_an", an, 4'hF);
    chk("de_k18_dp", {3'b0, dp}, 4'h0);
    repeat (8) @(negedge clk);
    chk("de_k26_an", an, 4'h7);
    digit_en = 4'hF; dp_in = 4'hF;
    repeat (9) @(negedge clk);
    chk("k35_an", an, 4'hE);
    chk("k35_dp", {3'b0, dp}, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_an", an, 4'hF);
    chk("async_dp", {3'b0, dp}, 4'h1);
    chk("async_sel", {2'b0, sel}, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (en) en = $urandom_range(99) != 0;
      else en = $urandom_range(3) == 0;
      if ($urandom_range(19) == 0) digit_en = 4'($urandom);
      if ($urandom_range(19) == 0) dp_in = 4'($urandom);
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
